// File: rtl/fetch_unit.sv
// Instruction prefetch stage: issues 4-byte MMU reads into an 8-byte FIFO and
// presents up to 4 bytes plus their PC to the decoder; jumps flush and refetch.
module fetch_unit #(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_PC   = 24'h000100,
  parameter int unsigned       FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic [1:0]        mem_byteCount,
  input  logic [31:0]       mem_dataOut,
  input  logic              mem_dataOutReady,
  output logic [31:0]       instr_bytes,
  output logic [2:0]        instr_avail,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic [2:0]        consume,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(4);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t            state, state_n;
  logic              mem_read_n;
  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] fetch_ptr, fetch_ptr_n;
  logic [ADDR_W-1:0] pc_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
  logic              discard, discard_n;
  logic              push;
  logic [2:0]        consume_eff;
  logic [7:0]        fifo_mem [FIFO_DEPTH];

  assign mem_byteCount = 2'd3;
  assign instr_avail   = (count > WORD_BYTES) ? 3'd4 : count[2:0];
  assign consume_eff   = (consume > instr_avail) ? instr_avail : consume;

  always_comb begin
    instr_bytes = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < instr_avail) begin
        instr_bytes[8*i +: 8] = fifo_mem[rd_ptr + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    state_n     = state;
    mem_read_n  = mem_read;
    addr_n      = mem_address;
    fetch_ptr_n = fetch_ptr;
    discard_n   = discard;
    push        = 1'b0;
    count_n     = count - CNT_W'(consume_eff);
    rd_ptr_n    = rd_ptr + PTR_W'(consume_eff);
    wr_ptr_n    = wr_ptr;
    pc_n        = instr_pc + ADDR_W'(consume_eff);

    if (jump) begin
      count_n     = '0;
      rd_ptr_n    = '0;
      wr_ptr_n    = '0;
      pc_n        = jump_addr;
      fetch_ptr_n = jump_addr;
    end

    unique case (state)
      IDLE: begin
        if (jump) begin
          addr_n = jump_addr;
        end else if (count <= WORD_BYTES) begin
          mem_read_n = 1'b1;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (mem_dataOutReady) begin
          // Data returned for a pre-jump address (or on the jump edge itself)
          // is dropped; fetch_ptr already holds the redirect target then.
          if (!jump && !discard) begin
            push        = 1'b1;
            count_n     = count_n + WORD_BYTES;
            wr_ptr_n    = wr_ptr + PTR_W'(4);
            fetch_ptr_n = fetch_ptr + ADDR_W'(4);
          end
          discard_n = 1'b0;
          addr_n    = fetch_ptr_n;
          if (count_n > WORD_BYTES) begin
            mem_read_n = 1'b0;
            state_n    = IDLE;
          end
        end else if (jump) begin
          discard_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_address <= RESET_PC;
      fetch_ptr   <= RESET_PC;
      instr_pc    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      discard     <= 1'b0;
    end else begin
      state       <= state_n;
      mem_read    <= mem_read_n;
      mem_address <= addr_n;
      fetch_ptr   <= fetch_ptr_n;
      instr_pc    <= pc_n;
      count       <= count_n;
      rd_ptr      <= rd_ptr_n;
      wr_ptr      <= wr_ptr_n;
      discard     <= discard_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      for (int unsigned k = 0; k < 4; k++) begin
        fifo_mem[wr_ptr + PTR_W'(k)] <= mem_dataOut[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: expected decoder views and MMU request
// addresses are queued by the stimulus and popped by independent monitors.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] mem_address;
  logic        mem_read;
  logic [1:0]  mem_byteCount;
  logic [31:0] mem_dataOut;
  logic        mem_dataOutReady;
  logic [31:0] instr_bytes;
  logic [2:0]  instr_avail;
  logic [23:0] instr_pc;
  logic [2:0]  consume;
  logic        jump;
  logic [23:0] jump_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [23:0] pc;
    logic [2:0]  avail;
    logic [31:0] bytes;
  } obs_t;

  obs_t        exp_obs[$];
  logic [23:0] exp_req[$];

  fetch_unit #(
    .ADDR_W(24),
    .RESET_PC(24'h000100),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_byteCount(mem_byteCount),
    .mem_dataOut(mem_dataOut),
    .mem_dataOutReady(mem_dataOutReady),
    .instr_bytes(instr_bytes),
    .instr_avail(instr_avail),
    .instr_pc(instr_pc),
    .consume(consume),
    .jump(jump),
    .jump_addr(jump_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'h000100: rom = 8'h05;
      24'h000101: rom = 8'hBA;
      24'h000102: rom = 8'hAD;
      24'h000103: rom = 8'h05;
      24'h000104: rom = 8'hF0;
      24'h000105: rom = 8'h0D;
      24'h000106: rom = 8'h10;
      24'h000107: rom = 8'h00;
      default:    rom = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push_obs(input logic [23:0] pc, input logic [2:0] avail, input logic [31:0] bytes);
    obs_t o;
    o.pc = pc;
    o.avail = avail;
    o.bytes = bytes;
    exp_obs.push_back(o);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    consume = 3'd0;
    jump = 1'b0;
    jump_addr = '0;
    step(3);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", {8'd0, mem_address}, 32'h000100);
    check("rst_instr_avail", {29'd0, instr_avail}, 32'd0);
    check("rst_instr_bytes", instr_bytes, 32'd0);
    check("rst_instr_pc", {8'd0, instr_pc}, 32'h000100);
    check("byte_count", {30'd0, mem_byteCount}, 32'd3);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((exp_obs.size() != 0 || exp_req.size() != 0) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_obs.size() != 0 || exp_req.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got obs_left=%0d req_left=%0d want 0/0", name, exp_obs.size(), exp_req.size());
    end
  endtask

  // MMU model: accepts a request seen after an edge, raises ready four edges later.
  initial begin : mmu
    bit          busy;
    int unsigned cnt;
    logic [23:0] addr;
    busy = 1'b0;
    cnt = 0;
    addr = '0;
    mem_dataOutReady = 1'b0;
    mem_dataOut = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_dataOutReady = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (mem_read) begin
          busy = 1'b1;
          cnt = 0;
          addr = mem_address;
          checks++;
          if (exp_req.size() == 0) begin
            failures++;
            $display("FAIL req_unexpected got addr=%h want none", addr);
          end else begin
            logic [23:0] e;
            e = exp_req.pop_front();
            if (addr !== e) begin
              failures++;
              $display("FAIL req_addr got=%h want=%h", addr, e);
            end
          end
        end
      end else begin
        cnt++;
        if (cnt == 4) begin
          check("req_held_read", {31'd0, mem_read}, 32'd1);
          check("req_held_addr", {8'd0, mem_address}, {8'd0, addr});
          mem_dataOut = {rom(addr + 24'd3), rom(addr + 24'd2), rom(addr + 24'd1), rom(addr)};
          mem_dataOutReady = 1'b1;
          busy = 1'b0;
        end
      end
    end
  end

  // Decoder-side monitor: every new non-empty view is one observation.
  initial begin : fetch_mon
    obs_t cur, last, e;
    bit   last_valid;
    last_valid = 1'b0;
    last = '0;
    forever begin
      @(negedge clk);
      if (rst || instr_avail == 3'd0) begin
        last_valid = 1'b0;
      end else begin
        cur.pc = instr_pc;
        cur.avail = instr_avail;
        cur.bytes = instr_bytes;
        if (!last_valid || cur != last) begin
          checks++;
          if (exp_obs.size() == 0) begin
            failures++;
            $display("FAIL obs_unexpected got pc=%h avail=%0d bytes=%h want none", cur.pc, cur.avail, cur.bytes);
          end else begin
            e = exp_obs.pop_front();
            if (cur != e) begin
              failures++;
              $display("FAIL obs got pc=%h avail=%0d bytes=%h want pc=%h avail=%0d bytes=%h",
                       cur.pc, cur.avail, cur.bytes, e.pc, e.avail, e.bytes);
            end
          end
        end
        last = cur;
        last_valid = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1;
    consume = 3'd0;
    jump = 1'b0;
    jump_addr = '0;

    // Consume 1 per cycle from the reset image (clamped while empty).
    do_reset();
    exp_req.push_back(24'h000100);
    exp_req.push_back(24'h000104);
    exp_req.push_back(24'h000108);
    push_obs(24'h000100, 3'd4, 32'h05ADBA05);
    push_obs(24'h000101, 3'd3, 32'h0005ADBA);
    push_obs(24'h000102, 3'd2, 32'h000005AD);
    push_obs(24'h000103, 3'd1, 32'h00000005);
    push_obs(24'h000104, 3'd4, 32'h00100DF0);
    push_obs(24'h000105, 3'd3, 32'h0000100D);
    push_obs(24'h000106, 3'd2, 32'h00000010);
    push_obs(24'h000107, 3'd1, 32'h00000000);
    release_rst();
    consume = 3'd1;
    step(1);
    check("first_mem_read", {31'd0, mem_read}, 32'd1);
    check("fill_avail", {29'd0, instr_avail}, 32'd0);
    repeat (4) begin
      step(1);
      check("fill_avail", {29'd0, instr_avail}, 32'd0);
    end
    step(1);
    check("first_push_avail", {29'd0, instr_avail}, 32'd4);
    check("b2b_mem_read", {31'd0, mem_read}, 32'd1);
    check("b2b_mem_address", {8'd0, mem_address}, 32'h000104);
    wait_drain("consume1");

    // Consume 0 forever: two reads fill the FIFO, then fetch stalls.
    do_reset();
    exp_req.push_back(24'h000100);
    exp_req.push_back(24'h000104);
    exp_req.push_back(24'h000108);
    push_obs(24'h000100, 3'd4, 32'h05ADBA05);
    push_obs(24'h000104, 3'd4, 32'h00100DF0);
    release_rst();
    step(11);
    check("full_mem_read", {31'd0, mem_read}, 32'd0);
    step(20);
    check("stall_mem_read", {31'd0, mem_read}, 32'd0);
    check("stall_avail", {29'd0, instr_avail}, 32'd4);
    check("stall_pc", {8'd0, instr_pc}, 32'h000100);
    check("stall_bytes", instr_bytes, 32'h05ADBA05);
    consume = 3'd4;
    step(1);
    consume = 3'd0;
    wait_drain("consume0");

    // Jump while the first read is in flight: its data is discarded.
    do_reset();
    exp_req.push_back(24'h000100);
    exp_req.push_back(24'h000104);
    exp_req.push_back(24'h000108);
    push_obs(24'h000104, 3'd4, 32'h00100DF0);
    release_rst();
    step(1);
    jump = 1'b1;
    jump_addr = 24'h000104;
    step(1);
    jump = 1'b0;
    check("discard_hold_read", {31'd0, mem_read}, 32'd1);
    check("discard_hold_addr", {8'd0, mem_address}, 32'h000100);
    check("discard_pc", {8'd0, instr_pc}, 32'h000104);
    repeat (8) begin
      check("discard_avail", {29'd0, instr_avail}, 32'd0);
      step(1);
    end
    wait_drain("jump_inflight");

    // Jump on the ready edge with consume=4: push dropped, refetch at target.
    do_reset();
    exp_req.push_back(24'h000100);
    exp_req.push_back(24'h000104);
    exp_req.push_back(24'h000102);
    exp_req.push_back(24'h000106);
    push_obs(24'h000100, 3'd4, 32'h05ADBA05);
    push_obs(24'h000102, 3'd4, 32'h0DF005AD);
    release_rst();
    step(10);
    jump = 1'b1;
    jump_addr = 24'h000102;
    consume = 3'd4;
    step(1);
    jump = 1'b0;
    consume = 3'd0;
    check("jr_avail", {29'd0, instr_avail}, 32'd0);
    check("jr_pc", {8'd0, instr_pc}, 32'h000102);
    check("jr_mem_address", {8'd0, mem_address}, 32'h000102);
    check("jr_mem_read", {31'd0, mem_read}, 32'd1);
    wait_drain("jump_ready");

    // Jump from IDLE to the top of the address space; addresses and PC wrap.
    do_reset();
    exp_req.push_back(24'hFFFFFC);
    exp_req.push_back(24'h000000);
    exp_req.push_back(24'h000004);
    push_obs(24'hFFFFFC, 3'd4, 32'hA5A4A7A6);
    push_obs(24'hFFFFFE, 3'd2, 32'h0000A5A4);
    push_obs(24'hFFFFFF, 3'd1, 32'h000000A5);
    push_obs(24'h000000, 3'd4, 32'h59585B5A);
    release_rst();
    jump = 1'b1;
    jump_addr = 24'hFFFFFC;
    step(1);
    jump = 1'b0;
    check("idle_jump_read", {31'd0, mem_read}, 32'd0);
    check("idle_jump_addr", {8'd0, mem_address}, 32'hFFFFFC);
    check("idle_jump_pc", {8'd0, instr_pc}, 32'hFFFFFC);
    step(1);
    check("idle_jump_req", {31'd0, mem_read}, 32'd1);
    begin
      int unsigned n = 0;
      while (instr_avail == 3'd0 && n < 20) begin
        step(1);
        n++;
      end
      check("wrap_fill", {31'd0, instr_avail != 3'd0}, 32'd1);
    end
    consume = 3'd2;
    step(1);
    consume = 3'd1;
    step(1);
    step(1);
    consume = 3'd0;
    check("wrap_pc", {8'd0, instr_pc}, 32'h000000);
    wait_drain("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
